// File: rtl/bte_pkg.sv
// Shared encodings for the block transfer engine: command opcodes and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package bte_pkg;

  typedef enum logic [1:0] {
    OP_FILL   = 2'd0,
    OP_COPY   = 2'd1,
    OP_SWAP   = 2'd2,
    OP_VERIFY = 2'd3
  } op_e;

  // Each non-idle state names the access that is currently outstanding.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_B = 3'd4
  } state_e;

endpackage

// File: rtl/block_transfer_engine_if.sv
// Toggle-handshake memory port between one arbitrator master and the arbitrator.
// Latency: n/a (wiring only); a request is pending while m_req != m_ack.
// Backpressure: the arbitrator stalls the master simply by delaying the m_ack toggle.
// Signals: m_req/m_ack toggle pair, m_we/m_a/m_d request fields, m_q read data
// (valid on the cycle m_ack becomes equal to m_req).
interface block_transfer_engine_if #(
  parameter int abits = 24,
  parameter int dbits = 8
);
  logic             m_req;
  logic             m_ack;
  logic             m_we;
  logic [abits-1:0] m_a;
  logic [dbits-1:0] m_d;
  logic [dbits-1:0] m_q;

  modport master (output m_req, m_we, m_a, m_d, input m_ack, m_q);
  modport slave  (input m_req, m_we, m_a, m_d, output m_ack, m_q);
endinterface

// File: rtl/bte_req_port.sv
// Request side of the toggle handshake: flips m_req and registers m_we/m_a/m_d on issue.
// Latency: request visible one edge after issue; completion seen combinationally.
// Backpressure: acc_idle stays low until the arbitrator echoes the toggle on m_ack.
// Ports: clk, reset_n, issue strobe with we/a/d fields, acc_idle (m_req == m_ack),
// mem (master side of the memory port).
module bte_req_port #(
  parameter int abits = 24,
  parameter int dbits = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    issue,
  input  logic                    we,
  input  logic [abits-1:0]        a,
  input  logic [dbits-1:0]        d,
  output logic                    acc_idle,
  block_transfer_engine_if.master mem
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem.m_req <= 1'b0;
      mem.m_we  <= 1'b0;
      mem.m_a   <= '0;
      mem.m_d   <= '0;
    end else if (issue) begin
      mem.m_req <= ~mem.m_req;
      mem.m_we  <= we;
      mem.m_a   <= a;
      mem.m_d   <= d;
    end
  end

  assign acc_idle = (mem.m_req == mem.m_ack);

endmodule

// File: rtl/block_transfer_engine.sv
// DMA sequencer for FILL/COPY/SWAP/VERIFY over one toggle-handshake arbitrator port.
// Latency: first access one edge after start; at least 2 cycles per access; done one cycle.
// Backpressure: holds each state until m_ack echoes m_req; start ignored while busy.
// Ports: clk, reset_n; cmd_* command (latched on accepted start); abort level;
// busy/done/st_fail/st_abort/fail_addr status; mem = master side of the memory port.
// Optional: define BTE_FIXADDR_EN to add cmd_src_fix/cmd_dst_fix, which hold the
// A or B address constant for the whole operation.
module block_transfer_engine
  import bte_pkg::*;
#(
  parameter int abits = 24,
  parameter int dbits = 8,
  parameter int lbits = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_start,
  input  logic [1:0]              cmd_op,
  input  logic [abits-1:0]        cmd_src,
  input  logic [abits-1:0]        cmd_dst,
  input  logic [lbits-1:0]        cmd_len,
  input  logic [dbits-1:0]        cmd_fill,
`ifdef BTE_FIXADDR_EN
  input  logic                    cmd_src_fix,
  input  logic                    cmd_dst_fix,
`endif
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    st_fail,
  output logic                    st_abort,
  output logic [abits-1:0]        fail_addr,
  block_transfer_engine_if.master mem
);

  state_e           state;
  op_e              op_q;
  logic [abits-1:0] a_q, b_q;
  logic [dbits-1:0] t_q, u_q, fill_q;
  logic [lbits:0]   rem_q;      // one bit wider so len=0 can hold 2^lbits
  logic             launch_q;   // first access of the operation not yet issued
  logic             src_fix_q, dst_fix_q;

  logic             acc_idle;
  logic             want, go, word_end, first_acc;
  logic             fin_ok, fin_abort, fin_fail;
  state_e           want_st;
  logic             want_we;
  logic [abits-1:0] want_a, a_nxt, b_nxt, fa_x, fa_y;
  logic [dbits-1:0] want_d;

  assign a_nxt = src_fix_q ? a_q : a_q + abits'(1);
  assign b_nxt = dst_fix_q ? b_q : b_q + abits'(1);

  // Next-access decision, evaluated only when no request is outstanding.
  always_comb begin
    want      = 1'b0;
    want_st   = ST_IDLE;
    want_we   = 1'b0;
    want_a    = '0;
    want_d    = '0;
    word_end  = 1'b0;
    fin_fail  = 1'b0;
    first_acc = 1'b0;
    fa_x      = a_q;
    fa_y      = b_q;
    if (state != ST_IDLE) begin
      if (launch_q) begin
        first_acc = 1'b1;
      end else if (acc_idle) begin
        case (state)
          ST_RD_A: begin
            want   = 1'b1;
            want_a = b_q;
            if (op_q == OP_COPY) begin
              // Forward the read data straight into the write; T captures it too.
              want_st = ST_WR_B;
              want_we = 1'b1;
              want_d  = mem.m_q;
            end else begin
              want_st = ST_RD_B;
            end
          end
          ST_RD_B: begin
            if (op_q == OP_SWAP) begin
              want    = 1'b1;
              want_st = ST_WR_B;
              want_we = 1'b1;
              want_a  = b_q;
              want_d  = t_q;
            end else if (mem.m_q != t_q) begin
              fin_fail = 1'b1;
            end else begin
              word_end = 1'b1;
            end
          end
          ST_WR_B: begin
            if (op_q == OP_SWAP) begin
              want    = 1'b1;
              want_st = ST_WR_A;
              want_we = 1'b1;
              want_a  = a_q;
              want_d  = u_q;
            end else begin
              word_end = 1'b1;
            end
          end
          ST_WR_A:  word_end = 1'b1;
          default:  ;
        endcase
      end
    end

    fin_ok = word_end && (rem_q == (lbits+1)'(1));
    if (word_end && !fin_ok) begin
      first_acc = 1'b1;
      fa_x      = a_nxt;
      fa_y      = b_nxt;
    end

    if (first_acc) begin
      want = 1'b1;
      if (op_q == OP_FILL) begin
        want_st = ST_WR_B;
        want_we = 1'b1;
        want_a  = fa_y;
        want_d  = fill_q;
      end else begin
        want_st = ST_RD_A;
        want_a  = fa_x;
      end
    end

    // Abort only suppresses a new access; a finishing word wins over abort.
    fin_abort = want && abort;
    go        = want && !abort;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_FILL;
      a_q       <= '0;
      b_q       <= '0;
      t_q       <= '0;
      u_q       <= '0;
      fill_q    <= '0;
      rem_q     <= '0;
      launch_q  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      st_fail   <= 1'b0;
      st_abort  <= 1'b0;
      fail_addr <= '0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (cmd_start) begin
          op_q     <= op_e'(cmd_op);
          a_q      <= cmd_src;
          b_q      <= cmd_dst;
          fill_q   <= cmd_fill;
          rem_q    <= (cmd_len == '0) ? {1'b1, {lbits{1'b0}}} : {1'b0, cmd_len};
          launch_q <= 1'b1;
          busy     <= 1'b1;
          st_fail  <= 1'b0;
          st_abort <= 1'b0;
          state    <= (op_e'(cmd_op) == OP_FILL) ? ST_WR_B : ST_RD_A;
        end
      end else begin
        if (acc_idle && !launch_q) begin
          if (state == ST_RD_A) t_q <= mem.m_q;
          if (state == ST_RD_B) u_q <= mem.m_q;
        end
        if (word_end) begin
          a_q   <= a_nxt;
          b_q   <= b_nxt;
          rem_q <= rem_q - (lbits+1)'(1);
        end
        if (go) begin
          state    <= want_st;
          launch_q <= 1'b0;
        end
        if (fin_ok || fin_abort || fin_fail) begin
          state    <= ST_IDLE;
          launch_q <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
          st_abort <= fin_abort;
          st_fail  <= fin_fail;
          if (fin_fail) fail_addr <= a_q;
        end
      end
    end
  end

`ifdef BTE_FIXADDR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_fix_q <= 1'b0;
      dst_fix_q <= 1'b0;
    end else if (state == ST_IDLE && cmd_start) begin
      src_fix_q <= cmd_src_fix;
      dst_fix_q <= cmd_dst_fix;
    end
  end
`else
  assign src_fix_q = 1'b0;
  assign dst_fix_q = 1'b0;
`endif

  bte_req_port #(
    .abits (abits),
    .dbits (dbits)
  ) u_req_port (
    .clk      (clk),
    .reset_n  (reset_n),
    .issue    (go),
    .we       (want_we),
    .a        (want_a),
    .d        (want_d),
    .acc_idle (acc_idle),
    .mem      (mem)
  );

endmodule

// File: tb/tb_block_transfer_engine.sv
// Bench for block_transfer_engine with a toggle-handshake arbitrator/RAM model.
// Latency: arbitrator acknowledges after a programmable number of cycles.
// Backpressure: one outstanding request at a time, matching the engine.
module tb_block_transfer_engine;

  typedef struct packed {
    logic        we;
    logic [23:0] a;
    logic [7:0]  d;
  } acc_t;

  typedef struct {
    logic [1:0]  op;
    logic [23:0] src;
    logic [23:0] dst;
    logic [3:0]  len;
    logic [7:0]  fill;
    int          lat;
    int          exp_acc;
    logic        exp_fail;
    logic [23:0] exp_faddr;
    logic        exp_lwe;
    logic [23:0] exp_la;
    logic [7:0]  exp_ld;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        cmd_start;
  logic [1:0]  cmd_op;
  logic [23:0] cmd_src, cmd_dst;
  logic [3:0]  cmd_len;
  logic [7:0]  cmd_fill;
  logic        abort;
  logic        busy, done, st_fail, st_abort;
  logic [23:0] fail_addr;

  block_transfer_engine_if #(.abits(24), .dbits(8)) mif ();

  block_transfer_engine #(.abits(24), .dbits(8), .lbits(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_start (cmd_start),
    .cmd_op    (cmd_op),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_len   (cmd_len),
    .cmd_fill  (cmd_fill),
`ifdef BTE_FIXADDR_EN
    .cmd_src_fix (1'b0),
    .cmd_dst_fix (1'b0),
`endif
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .st_fail   (st_fail),
    .st_abort  (st_abort),
    .fail_addr (fail_addr),
    .mem       (mif)
  );

  bit [7:0] ram [bit [23:0]];
  acc_t     log_q [$];
  int       lat = 1;
  int       done_total = 0;
  int       total = 0;
  int       bad = 0;
  vec_t     vecs [6];
  int       bases [6];
  acc_t     exp_sw [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [23:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  // Arbitrator + RAM model: completes the pending request after lat cycles.
  initial begin
    int   wcnt;
    acc_t e;
    wcnt = 0;
    mif.m_ack = 1'b0;
    mif.m_q   = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        mif.m_ack = 1'b0;
        mif.m_q   = 8'h00;
        wcnt      = 0;
      end else if (mif.m_req != mif.m_ack) begin
        wcnt++;
        if (wcnt >= lat) begin
          e.we = mif.m_we;
          e.a  = mif.m_a;
          e.d  = mif.m_d;
          log_q.push_back(e);
          if (mif.m_we) ram[mif.m_a] = mif.m_d;
          else          mif.m_q = rd(mif.m_a);
          mif.m_ack = mif.m_req;
          wcnt      = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done) done_total++;
    end
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s #%0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL %s timeout: busy still 1 after %0d cycles", nm, n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [23:0] src, input logic [23:0] dst,
                          input logic [3:0] len, input logic [7:0] fill, input int l);
    lat       = l;
    cmd_op    = op;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_len   = len;
    cmd_fill  = fill;
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  initial begin
    int   base, dcnt, hit;
    acc_t last;

    vecs[0] = '{op:2'd0, src:24'h000000, dst:24'h000100, len:4'd4, fill:8'hA5, lat:3, exp_acc:4,
                exp_fail:1'b0, exp_faddr:24'h0, exp_lwe:1'b1, exp_la:24'h000103, exp_ld:8'hA5};
    vecs[1] = '{op:2'd1, src:24'h000200, dst:24'hFFFFFE, len:4'd3, fill:8'h00, lat:1, exp_acc:6,
                exp_fail:1'b0, exp_faddr:24'h0, exp_lwe:1'b1, exp_la:24'h000000, exp_ld:8'h33};
    vecs[2] = '{op:2'd2, src:24'h000010, dst:24'h000020, len:4'd2, fill:8'h00, lat:2, exp_acc:8,
                exp_fail:1'b0, exp_faddr:24'h0, exp_lwe:1'b1, exp_la:24'h000011, exp_ld:8'h44};
    vecs[3] = '{op:2'd3, src:24'h000040, dst:24'h000060, len:4'd5, fill:8'h00, lat:1, exp_acc:6,
                exp_fail:1'b1, exp_faddr:24'h000042, exp_lwe:1'b0, exp_la:24'h000062, exp_ld:8'h00};
    vecs[4] = '{op:2'd3, src:24'h000040, dst:24'h000060, len:4'd2, fill:8'h00, lat:3, exp_acc:4,
                exp_fail:1'b0, exp_faddr:24'h0, exp_lwe:1'b0, exp_la:24'h000061, exp_ld:8'h00};
    vecs[5] = '{op:2'd0, src:24'h000000, dst:24'h000500, len:4'd0, fill:8'h5A, lat:1, exp_acc:16,
                exp_fail:1'b0, exp_faddr:24'h0, exp_lwe:1'b1, exp_la:24'h00050F, exp_ld:8'h5A};

    exp_sw[0] = {1'b0, 24'h10, 8'h00};
    exp_sw[1] = {1'b0, 24'h20, 8'h00};
    exp_sw[2] = {1'b1, 24'h20, 8'h11};
    exp_sw[3] = {1'b1, 24'h10, 8'h33};
    exp_sw[4] = {1'b0, 24'h11, 8'h00};
    exp_sw[5] = {1'b0, 24'h21, 8'h00};
    exp_sw[6] = {1'b1, 24'h21, 8'h22};
    exp_sw[7] = {1'b1, 24'h11, 8'h44};

    ram[24'h200] = 8'h31; ram[24'h201] = 8'h32; ram[24'h202] = 8'h33;
    ram[24'h10] = 8'h11;  ram[24'h11] = 8'h22;
    ram[24'h20] = 8'h33;  ram[24'h21] = 8'h44;
    ram[24'h40] = 8'h01; ram[24'h41] = 8'h02; ram[24'h42] = 8'h03; ram[24'h43] = 8'h04; ram[24'h44] = 8'h05;
    ram[24'h60] = 8'h01; ram[24'h61] = 8'h02; ram[24'h62] = 8'h99; ram[24'h63] = 8'h04; ram[24'h64] = 8'h05;
    for (int k = 0; k < 10; k++) ram[24'h300 + 24'(k)] = 8'h70 + 8'(k);

    reset_n = 1'b0; cmd_start = 1'b0; cmd_op = 2'd0; cmd_src = '0; cmd_dst = '0;
    cmd_len = '0; cmd_fill = '0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    chk("rst_busy",      -1, 32'(busy), 32'd0);
    chk("rst_done",      -1, 32'(done), 32'd0);
    chk("rst_st",        -1, 32'({st_fail, st_abort}), 32'd0);
    chk("rst_fail_addr", -1, 32'(fail_addr), 32'd0);
    chk("rst_m_req",     -1, 32'(mif.m_req), 32'd0);
    chk("rst_m_bus",     -1, 32'({mif.m_we, mif.m_a} ^ {1'b0, 16'h0, mif.m_d}), 32'd0);

    for (int i = 0; i < 6; i++) begin
      base     = log_q.size();
      bases[i] = base;
      dcnt     = done_total;
      start_op(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].fill, vecs[i].lat);
      wait_idle("vec");
      chk("acc_count", i, 32'(log_q.size() - base), 32'(vecs[i].exp_acc));
      chk("done_pulses", i, 32'(done_total - dcnt), 32'd1);
      chk("busy_after", i, 32'(busy), 32'd0);
      chk("st_fail", i, 32'(st_fail), 32'(vecs[i].exp_fail));
      chk("st_abort", i, 32'(st_abort), 32'd0);
      chk("req_eq_ack", i, 32'(mif.m_req), 32'(mif.m_ack));
      if (vecs[i].exp_fail) chk("fail_addr", i, 32'(fail_addr), 32'(vecs[i].exp_faddr));
      if (log_q.size() > base) begin
        last = log_q[log_q.size() - 1];
        chk("last_we", i, 32'(last.we), 32'(vecs[i].exp_lwe));
        chk("last_addr", i, 32'(last.a), 32'(vecs[i].exp_la));
        if (vecs[i].exp_lwe) chk("last_data", i, 32'(last.d), 32'(vecs[i].exp_ld));
      end
    end

    for (int k = 0; k < 4; k++) chk("fill_mem", k, 32'(rd(24'h100 + 24'(k))), 32'hA5);
    chk("fill_mem_past", 4, 32'(rd(24'h104)), 32'h00);
    chk("copy_wrap", 0, 32'(rd(24'hFFFFFE)), 32'h31);
    chk("copy_wrap", 1, 32'(rd(24'hFFFFFF)), 32'h32);
    chk("copy_wrap", 2, 32'(rd(24'h000000)), 32'h33);
    chk("swap_mem", 0, 32'({rd(24'h10), rd(24'h11)}), 32'h3344);
    chk("swap_mem", 1, 32'({rd(24'h20), rd(24'h21)}), 32'h1122);
    for (int k = 0; k < 8; k++) begin
      if (bases[2] + k < log_q.size()) begin
        chk("swap_order_we", k, 32'(log_q[bases[2] + k].we), 32'(exp_sw[k].we));
        chk("swap_order_a", k, 32'(log_q[bases[2] + k].a), 32'(exp_sw[k].a));
        if (exp_sw[k].we) chk("swap_order_d", k, 32'(log_q[bases[2] + k].d), 32'(exp_sw[k].d));
      end
    end
    chk("len0_last", 0, 32'(rd(24'h50F)), 32'h5A);
    chk("len0_past", 0, 32'(rd(24'h510)), 32'h00);

    // Abort while the R(A) of the second COPY word is outstanding.
    base = log_q.size();
    dcnt = done_total;
    start_op(2'd1, 24'h300, 24'h400, 4'd10, 8'h00, 3);
    hit = 0;
    for (int c = 0; c < 300 && hit == 0; c++) begin
      @(posedge clk); #2;
      if (log_q.size() - base == 2 && mif.m_req != mif.m_ack) begin
        abort = 1'b1;
        hit   = 1;
      end
    end
    chk("abort_window", 0, 32'(hit), 32'd1);
    wait_idle("abort");
    abort = 1'b0;
    chk("abort_acc", 0, 32'(log_q.size() - base), 32'd3);
    chk("abort_st", 0, 32'({st_abort, st_fail}), 32'b10);
    chk("abort_done", 0, 32'(done_total - dcnt), 32'd1);
    chk("abort_req_ack", 0, 32'(mif.m_req), 32'(mif.m_ack));
    chk("abort_mem", 0, 32'({rd(24'h400), rd(24'h401)}), 32'h7000);
    if (log_q.size() > base) begin
      last = log_q[log_q.size() - 1];
      chk("abort_last", 0, 32'({last.we, last.a}), 32'({1'b0, 24'h301}));
    end

    // Reset asserted in the middle of a SWAP.
    base = log_q.size();
    start_op(2'd2, 24'h10, 24'h20, 4'd2, 8'h00, 2);
    hit = 0;
    for (int c = 0; c < 300 && hit == 0; c++) begin
      @(posedge clk); #2;
      if (log_q.size() - base >= 3) hit = 1;
    end
    chk("midswap_reach", 0, 32'(hit), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy_done", 0, 32'({busy, done}), 32'd0);
    chk("midrst_st", 0, 32'({st_fail, st_abort}), 32'd0);
    chk("midrst_fail_addr", 0, 32'(fail_addr), 32'd0);
    chk("midrst_m_req_we", 0, 32'({mif.m_req, mif.m_we}), 32'd0);
    chk("midrst_m_a", 0, 32'(mif.m_a), 32'd0);
    chk("midrst_m_d", 0, 32'(mif.m_d), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Engine is usable again after reset.
    base = log_q.size();
    dcnt = done_total;
    start_op(2'd0, 24'h0, 24'h700, 4'd2, 8'hC3, 1);
    wait_idle("post_reset");
    chk("post_rst_acc", 0, 32'(log_q.size() - base), 32'd2);
    chk("post_rst_mem", 0, 32'({rd(24'h700), rd(24'h701), rd(24'h702)}), 32'hC3C300);
    chk("post_rst_done", 0, 32'(done_total - dcnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
